load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-stage load/store unit between the MIPS pipeline's memory stage and the word-wide, single-port data memory. The data memory has 1-cycle synchronous reads and no byte enables.
- Converts byte addresses to word addresses.
- Extracts and sign/zero-extends sub-word loads.
- Performs read-modify-write for byte and halfword stores.
- Flags misaligned accesses.
- Backpressures the pipeline with req_ready.

Parameters:
ADDR_W, 8, data-memory word-address width; the memory holds 2**ADDR_W words.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  memory-stage access request
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
req_unsigned  in  1  load zero-extends when 1 (lbu/lhu)
req_addr  in  32  byte address (ALU result)
req_wdata  in  32  store data, right-justified
req_ready  out  1  unit can accept a request this cycle (pipeline stalls when low)
rsp_valid  out  1  load data valid this cycle
rsp_rdata  out  32  extended load data
rsp_err  out  1  one-cycle pulse: misaligned access
mem_addr  out  ADDR_W  data-memory word address
mem_wdata  out  32  data-memory write data
mem_wren  out  1  data-memory write enable
mem_q  in  32  data-memory read data, valid the cycle after the address

Behaviour:
- Word address = req_addr[ADDR_W+1:2]. Little-endian lanes: byte k = bits 8k+7:8k. Half h = bits 16h+15:16h.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- Accept = req_valid & req_ready. req_ready = 1 only in IDLE and not in reset.
- States: IDLE, LOAD_WAIT, RMW, ERR. A shared package holds the enum.
- IDLE:
  - mem_addr is driven combinationally from req_addr.
  - Aligned word store accepted: mem_wren=1 and mem_wdata=req_wdata the same cycle; stay in IDLE. No response.
  - Aligned load accepted: capture size, unsigned and addr[1:0]; go to LOAD_WAIT.
  - Aligned byte/half store accepted: capture address, size and data; mem_wren=0; go to RMW.
  - Misaligned access accepted: no write; go to ERR.
  - No request: mem_wren=0; mem_addr follows req_addr; the read is harmless.
- LOAD_WAIT:
  - mem_addr holds the captured word address.
  - rsp_valid=1; rsp_rdata = lane of mem_q selected by captured addr/size, extended per req_unsigned.
  - Returns to IDLE. Load latency is 1 cycle after accept; throughput is one load per 2 cycles.
- RMW:
  - mem_q holds the old word. mem_wdata = old word with the target lane(s) replaced by req_wdata[7:0] or [15:0].
  - mem_wren=1, mem_addr = captured address. Returns to IDLE. A sub-word store occupies 2 cycles.
- ERR:
  - rsp_err=1. If the request was a load, rsp_valid=1 and rsp_rdata=0. mem_wren=0.
  - Returns to IDLE.
- rsp_valid, rsp_rdata and rsp_err are 0 in every state where they are not defined above.
- Reset (synchronous, any state):
  - Next state is IDLE; captured registers are cleared to 0.
  - During a reset cycle, mem_wren=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0 and mem_addr=0. A reset in RMW aborts the write and memory is unchanged.
- req_* is ignored outside IDLE. Upstream must hold the request while req_ready=0.
- A store followed by a load of the same word, back-to-back, reads the new data, because the write commits at the edge before the load's address is registered.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - state enum lsu_state_t.
  - function is_misaligned(size, addr[1:0]).
- Sub-module lsu_lane_align (combinational). It provides:
  - load extract/extend: mem_q, size, offset, unsigned -> rdata.
  - store merge: old, new, size, offset -> merged word.
- FSM, capture registers and memory muxing live in load_store_unit.

Test Plan:
1. Memory word 4 = 0x8899AABB; lw addr 0x10 -> next cycle rsp_valid=1, rsp_rdata=0x8899AABB; req_ready low for 1 cycle.
2. lb 0x13 -> 0xFFFFFF88; lbu 0x13 -> 0x00000088; lh 0x12 -> 0xFFFF8899; lhu 0x10 -> 0x0000AABB.
3. sb 0x11, wdata 0x000000CC -> RMW cycle has mem_wren=1, mem_addr=4, mem_wdata=0x8899CCBB; follow-up lw 0x10 returns 0x8899CCBB.
4. sw 0x12 (misaligned) -> no mem_wren at any cycle, rsp_err pulses 1 cycle, word unchanged. lh 0x11 -> rsp_err=1, rsp_valid=1, rsp_rdata=0.
5. sh 0x10, wdata 0x1234, with reset asserted in the RMW cycle -> mem_wren=0, word 4 unchanged, next cycle IDLE with req_ready=1.
6. sw 0x20 (0xDEADBEEF) then lw 0x20 back-to-back -> store completes in 1 cycle with req_ready staying high; load returns 0xDEADBEEF.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and alignment check for the load/store unit
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW, ERR} lsu_state_t;

    // size 2'b11 behaves as a word access
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return size[1] ? |off : (size == SZ_HALF) & off[0];
    endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: pipeline request/response and data-memory signals of the load/store unit
interface lsu_if #(parameter int ADDR_W = 8);
    logic              req_valid;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_wren;
    logic [31:0]       mem_q;

    modport master(
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_q,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_wren
    );
    modport slave(
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_q,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian sub-word load extraction/extension and store lane merge
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_q,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = mem_q[{off, 3'b000} +: 8];
    assign h = off[1] ? mem_q[31:16] : mem_q[15:0];
    assign rdata = size[1] ? mem_q :
                   (size == SZ_HALF) ? {{16{~uns & h[15]}}, h} : {{24{~uns & b[7]}}, b};

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign merged[8*k +: 8] = size[1] ? wdata[8*k +: 8] :
                                  (size == SZ_HALF) ? ((off[1] == (k >= 2)) ? wdata[8*(k%2) +: 8] : mem_q[8*k +: 8]) :
                                  ((off == 2'(k)) ? wdata[7:0] : mem_q[8*k +: 8]);
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage LSU with sub-word loads, read-modify-write stores and misalignment errors
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input logic  clk,
    input logic  reset,
    lsu_if.slave bus
);
    lsu_state_t        state;
    logic [ADDR_W-1:0] cap_addr;
    logic [1:0]        cap_size;
    logic [1:0]        cap_off;
    logic              cap_uns;
    logic              cap_write;
    logic [31:0]       cap_wdata;
    logic              mis;
    logic              idle;
    logic [31:0]       ld_data;
    logic [31:0]       merged;

    assign mis  = is_misaligned(bus.req_size, bus.req_addr[1:0]);
    assign idle = (state == IDLE) && !reset;

    lsu_lane_align u_align (
        .mem_q  (bus.mem_q),
        .size   (cap_size),
        .off    (cap_off),
        .uns    (cap_uns),
        .wdata  (cap_wdata),
        .rdata  (ld_data),
        .merged (merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cap_addr  <= '0;
            cap_size  <= '0;
            cap_off   <= '0;
            cap_uns   <= 1'b0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
        end else if (state == IDLE && bus.req_valid) begin
            cap_addr  <= bus.req_addr[ADDR_W+1:2];
            cap_size  <= bus.req_size;
            cap_off   <= bus.req_addr[1:0];
            cap_uns   <= bus.req_unsigned;
            cap_write <= bus.req_write;
            cap_wdata <= bus.req_wdata;
            state     <= mis ? ERR : !bus.req_write ? LOAD_WAIT : bus.req_size[1] ? IDLE : RMW;
        end else begin
            state <= IDLE;
        end
    end

    assign bus.req_ready = idle;
    assign bus.mem_addr  = reset ? '0 : (state == IDLE) ? bus.req_addr[ADDR_W+1:2] : cap_addr;
    // aligned word stores write straight through; sub-word stores write back the merged word in RMW
    assign bus.mem_wren  = !reset && ((state == RMW) ||
                           (idle && bus.req_valid && bus.req_write && bus.req_size[1] && !mis));
    assign bus.mem_wdata = (state == RMW) ? merged : bus.req_wdata;
    assign bus.rsp_valid = !reset && ((state == LOAD_WAIT) || (state == ERR && !cap_write));
    assign bus.rsp_rdata = (!reset && state == LOAD_WAIT) ? ld_data : '0;
    assign bus.rsp_err   = !reset && (state == ERR);
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with response/write scoreboards for load_store_unit
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsu_if #(.ADDR_W(8)) bus ();

    load_store_unit #(.ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_q <= mem[bus.mem_addr];
    end

    int pass_n = 0;
    int total = 0;
    logic [33:0] exp_rsp [$];
    logic [39:0] exp_wr [$];

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) pass_n++;
        else $display("FAIL %s got=%h exp=%h", n, got, exp);
    endtask

    always @(negedge clk) begin
        if (bus.rsp_valid || bus.rsp_err) begin
            if (exp_rsp.size() == 0) begin
                total++;
                $display("FAIL unexpected_rsp got=%h exp=none", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata});
            end else chk("rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 64'(exp_rsp.pop_front()));
        end
        if (bus.mem_wren) begin
            if (exp_wr.size() == 0) begin
                total++;
                $display("FAIL unexpected_write got=%h exp=none", {bus.mem_addr, bus.mem_wdata});
            end else chk("mem_write", 64'({bus.mem_addr, bus.mem_wdata}), 64'(exp_wr.pop_front()));
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_size = sz;
        bus.req_unsigned = u;
        bus.req_addr = a;
        bus.req_wdata = wd;
        #1;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.req_ready) begin
            total++;
            $display("FAIL issue_timeout got=ready0 exp=ready1 addr=%h", a);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[4] = 32'h8899AABB;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size = SZ_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h10;
        bus.req_wdata = 32'h0;
        @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_wren", 64'(bus.mem_wren), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        reset = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("idle_ready", 64'(bus.req_ready), 64'd1);
        chk("idle_mem_addr", 64'(bus.mem_addr), 64'd4);

        exp_rsp.push_back({2'b10, 32'h8899AABB});
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 0);
        chk("lw_ready_low", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("lw_ready_back", 64'(bus.req_ready), 64'd1);

        exp_rsp.push_back({2'b10, 32'hFFFFFF88});
        issue(1'b0, SZ_BYTE, 1'b0, 32'h13, 0);
        exp_rsp.push_back({2'b10, 32'h00000088});
        issue(1'b0, SZ_BYTE, 1'b1, 32'h13, 0);
        exp_rsp.push_back({2'b10, 32'hFFFF8899});
        issue(1'b0, SZ_HALF, 1'b0, 32'h12, 0);
        exp_rsp.push_back({2'b10, 32'h0000AABB});
        issue(1'b0, SZ_HALF, 1'b1, 32'h10, 0);

        exp_wr.push_back({8'd4, 32'h8899CCBB});
        issue(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h000000CC);
        exp_rsp.push_back({2'b10, 32'h8899CCBB});
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 0);

        exp_rsp.push_back({2'b01, 32'h0});
        issue(1'b1, SZ_WORD, 1'b0, 32'h12, 32'h11111111);
        exp_rsp.push_back({2'b11, 32'h0});
        issue(1'b0, SZ_HALF, 1'b0, 32'h11, 0);

        issue(1'b1, SZ_HALF, 1'b0, 32'h10, 32'h00001234);
        reset = 1'b1;
        #1;
        chk("rmw_rst_wren", 64'(bus.mem_wren), 64'd0);
        chk("rmw_rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rmw_rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rmw_rst_idle_ready", 64'(bus.req_ready), 64'd1);
        chk("rmw_rst_word4", 64'(mem[4]), 64'h8899CCBB);

        exp_wr.push_back({8'd8, 32'hDEADBEEF});
        issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'hDEADBEEF);
        chk("sw_ready_high", 64'(bus.req_ready), 64'd1);
        exp_rsp.push_back({2'b10, 32'hDEADBEEF});
        issue(1'b0, SZ_WORD, 1'b0, 32'h20, 0);

        exp_wr.push_back({8'd8, 32'h5566BEEF});
        issue(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h00005566);
        exp_rsp.push_back({2'b10, 32'h00005566});
        issue(1'b0, SZ_HALF, 1'b0, 32'h22, 0);
        exp_rsp.push_back({2'b10, 32'hFFFFFFBE});
        issue(1'b0, SZ_BYTE, 1'b0, 32'h21, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);
        chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        chk("final_word4", 64'(mem[4]), 64'h8899CCBB);
        chk("final_word8", 64'(mem[8]), 64'h5566BEEF);
        $display("%0d/%0d checks passed", pass_n, total);
        $finish;
    end
endmodule
